// File: rtl/logic16_result_stage.sv
// Registered bitwise-op result stage with a 2-entry skid buffer and zr/ng flags.
// Optional macro RESULT_PARITY_EN adds a stored per-entry parity output (out_parity).
module logic16_result_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic [15:0]      out_count
`ifdef RESULT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic               main_zr_q, main_zr_d, skid_zr_q, skid_zr_d;
    logic               main_ng_q, main_ng_d, skid_ng_q, skid_ng_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   res_c;
    logic               accept_c, deliver_c;
`ifdef RESULT_PARITY_EN
    logic               main_par_q, main_par_d, skid_par_q, skid_par_d;
`endif

    // Result is computed once at the input; flags travel with the entry.
    always_comb begin
        res_c = '0;
        case (in_op)
            2'b00:   res_c = in_a & in_b;
            2'b01:   res_c = in_a | in_b;
            2'b10:   res_c = in_a ^ in_b;
            default: res_c = ~(in_a & in_b);
        endcase
    end

    assign accept_c  = in_valid & in_ready_q;
    assign deliver_c = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_zr_d   = main_zr_q;
        main_ng_d   = main_ng_q;
        skid_data_d = skid_data_q;
        skid_zr_d   = skid_zr_q;
        skid_ng_d   = skid_ng_q;
`ifdef RESULT_PARITY_EN
        main_par_d  = main_par_q;
        skid_par_d  = skid_par_q;
`endif
        count_d     = count_q + CNT_W'(deliver_c);

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_d     = ST_ONE;
                    main_data_d = res_c;
                    main_zr_d   = (res_c == '0);
                    main_ng_d   = res_c[WIDTH-1];
`ifdef RESULT_PARITY_EN
                    main_par_d  = ^res_c;
`endif
                end
            end
            ST_ONE: begin
                if (accept_c && deliver_c) begin
                    main_data_d = res_c;
                    main_zr_d   = (res_c == '0);
                    main_ng_d   = res_c[WIDTH-1];
`ifdef RESULT_PARITY_EN
                    main_par_d  = ^res_c;
`endif
                end else if (accept_c) begin
                    state_d     = ST_FULL;
                    skid_data_d = res_c;
                    skid_zr_d   = (res_c == '0);
                    skid_ng_d   = res_c[WIDTH-1];
`ifdef RESULT_PARITY_EN
                    skid_par_d  = ^res_c;
`endif
                end else if (deliver_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver_c) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_zr_d   = skid_zr_q;
                    main_ng_d   = skid_ng_q;
`ifdef RESULT_PARITY_EN
                    main_par_d  = skid_par_q;
`endif
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_zr_q   <= 1'b0;
            main_ng_q   <= 1'b0;
            skid_data_q <= '0;
            skid_zr_q   <= 1'b0;
            skid_ng_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
`ifdef RESULT_PARITY_EN
            main_par_q  <= 1'b0;
            skid_par_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_zr_q   <= main_zr_d;
            main_ng_q   <= main_ng_d;
            skid_data_q <= skid_data_d;
            skid_zr_q   <= skid_zr_d;
            skid_ng_q   <= skid_ng_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
`ifdef RESULT_PARITY_EN
            main_par_q  <= main_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_data_q;
    assign out_zr     = main_zr_q;
    assign out_ng     = main_ng_q;
    assign out_count  = count_q;
`ifdef RESULT_PARITY_EN
    assign out_parity = main_par_q;
`endif

endmodule

// File: tb/tb_logic16_result_stage.sv
// Bench for logic16_result_stage: directed scenarios plus random traffic against a queue model.
module tb_logic16_result_stage;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_a, in_b, out_data;
    logic [1:0]    in_op;
    logic          out_zr, out_ng;
    logic [15:0]   out_count;
`ifdef RESULT_PARITY_EN
    logic          out_parity;
`endif

    logic [W-1:0]  exp_q[$];
    int unsigned   cnt_m;
    int            n_checks = 0;
    int            n_pass   = 0;

    logic16_result_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zr    (out_zr),
        .out_ng    (out_ng),
        .out_count (out_count)
`ifdef RESULT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // One clock: drive, check outputs at negedge against the model, update model at posedge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic rdy);
        bit acc, del;
        logic [W-1:0] h;
        in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = rdy;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("out_count", 32'(out_count), 32'(cnt_m % 65536));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check("out_data", 32'(out_data), 32'(h));
            check("out_zr", 32'(out_zr), 32'(h == 0));
            check("out_ng", 32'(out_ng), 32'(h >= 16'h8000));
`ifdef RESULT_PARITY_EN
            check("out_parity", 32'(out_parity), 32'($countones(h) % 2));
`endif
        end
        @(posedge clk);
        del = (exp_q.size() > 0) && rdy;
        acc = v && (exp_q.size() < 2);
        if (del) begin
            void'(exp_q.pop_front());
            cnt_m++;
        end
        if (acc) exp_q.push_back(ref_f(a, b, op));
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        cnt_m = 0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_zr", 32'(out_zr), 32'd0);
        check("rst_out_ng", 32'(out_ng), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic AND with latency 1
        step(1'b1, 16'h00FF, 16'h0F0F, 2'd0, 1'b1);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(out_data), 32'h000F);
        check("t2_zr", 32'(out_zr), 32'd0);
        check("t2_ng", 32'(out_ng), 32'd0);

        // Zero and negative flags
        step(1'b1, 16'hF0F0, 16'h0F0F, 2'd0, 1'b1);
        check("t3_data_and", 32'(out_data), 32'h0000);
        check("t3_zr", 32'(out_zr), 32'd1);
        step(1'b1, 16'hF0F0, 16'h0F0F, 2'd3, 1'b1);
        check("t3_data_nand", 32'(out_data), 32'hFFFF);
        check("t3_ng", 32'(out_ng), 32'd1);
        repeat (2) step(1'b0, '0, '0, 2'd0, 1'b1);

        // Backpressure: skid fills, third item waits
        step(1'b1, 16'h1234, 16'h00FF, 2'd0, 1'b0);
        step(1'b1, 16'h1234, 16'h00FF, 2'd1, 1'b0);
        step(1'b1, 16'h1234, 16'h00FF, 2'd2, 1'b0);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_head", 32'(out_data), 32'h0034);
        step(1'b1, 16'h1234, 16'h00FF, 2'd2, 1'b1);
        check("t4_second", 32'(out_data), 32'h12FF);
        step(1'b1, 16'h1234, 16'h00FF, 2'd2, 1'b1);
        check("t4_third", 32'(out_data), 32'h12CB);
        repeat (2) step(1'b0, '0, '0, 2'd0, 1'b1);

        // Full throughput streaming
        for (int i = 0; i < 256; i++) begin
            step(1'b1, W'(i), 16'h00FF, 2'd0, 1'b1);
            check("t5_stream", 32'(out_data), 32'(i & 8'hFF));
            check("t5_in_ready", 32'(in_ready), 32'd1);
        end
        repeat (2) step(1'b0, '0, '0, 2'd0, 1'b1);

        // Random traffic
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                 2'($urandom), 1'($urandom_range(0, 2) != 0));

        // Async reset while FULL
        step(1'b1, 16'hAAAA, 16'h5555, 2'd1, 1'b0);
        step(1'b1, 16'hAAAA, 16'h5555, 2'd2, 1'b0);
        check("t1_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_out_count", 32'(out_count), 32'd0);
        exp_q.delete();
        cnt_m = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counter wrap: 65537 deliveries
        for (int i = 0; i < 65538; i++)
            step(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b1);
        check("t6_count_wrap", 32'(out_count), 32'd1);
`ifdef RESULT_PARITY_EN
        step(1'b1, 16'h0007, 16'h0007, 2'd0, 1'b1);
        check("t6_parity_7", 32'(out_parity), 32'd1);
        step(1'b1, 16'h0003, 16'h0003, 2'd0, 1'b1);
        check("t6_parity_3", 32'(out_parity), 32'd0);
`endif
        repeat (2) step(1'b0, '0, '0, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
